conv2_stage3_pair_sequencer: RTL and testbench
==============================================

# conv2_stage3_pair_sequencer

Operand issuer and result collector for the stage-3 adder of convolution layer 2. It accepts a stream of 14-bit signed partial sums and pairs them in arrival order. Each pair is issued to the stage-3 adder as a one-cycle enable pulse. The 15-bit sum is captured on the adder's `done` and presented downstream on a valid/ready port. It drives the adder's input side and consumes its output side, so it sits between stage 2 and the layer-2 accumulator.

## Interface
- `TIMEOUT_CYCLES`, 8: cycles allowed between enable pulse and adder `done` (used only with `CONV2_DONE_TIMEOUT_EN`).
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: partial sum available.
- `in_data` in 14: signed partial sum.
- `in_last` in 1: marks final partial sum of a window.
- `in_ready` out 1: sequencer accepts `in_data` this cycle.
- `add_enable` out 1: enable to stage-3 adder.
- `add_input1` out 14: first operand.
- `add_input2` out 14: second operand.
- `add_output1` in 15: adder sum.
- `add_done` in 1: adder result valid.
- `out_valid` out 1: sum available.
- `out_data` out 15: signed pair sum.
- `out_last` out 1: sum belongs to the last pair of the window.
- `out_ready` in 1: downstream accepts.
- `timeout_err` out 1: sticky error flag (tied 0 without the macro).

## Operation
- FSM states: `GET_A`, `GET_B`, `ISSUE`, `WAIT_DONE`, `EMIT`.
- `GET_A`:
  - `in_ready`=1.
  - On accept, latch operand A.
  - If `in_last`=1, set B=0 and pair_last=1, then go to `ISSUE`. This is the odd-count pad.
  - Otherwise go to `GET_B`.
- `GET_B`:
  - `in_ready`=1.
  - On accept, latch B and pair_last=`in_last`, then go to `ISSUE`.
- `ISSUE`:
  - `add_enable`=1 for exactly one cycle.
  - `add_input1`=A and `add_input2`=B; both are held stable from `ISSUE` through `WAIT_DONE`.
  - Go to `WAIT_DONE`.
- `WAIT_DONE`:
  - `add_enable`=0.
  - When `add_done`=1, register `add_output1` into `out_data`, set `out_last`=pair_last, and go to `EMIT`.
- `EMIT`:
  - `out_valid`=1.
  - `out_data` and `out_last` are held until `out_valid && out_ready`, then go to `GET_A`.
- `in_ready`=0 in `ISSUE`, `WAIT_DONE` and `EMIT`. No input is buffered beyond one pair.
- Arithmetic is done in the adder. The sequencer never modifies the 15-bit sum; it is captured bit-exact.
- Operands outside the active pair are driven 0 when idle.

## Timing
- Reset values:
  - State=`GET_A`, `in_ready`=0 while `reset` is high.
  - `add_enable`=0, `add_input1`=0, `add_input2`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `timeout_err`=0.
- Adder contract: `add_done` is high in the cycle after `add_enable`, and `add_output1` is valid in that same cycle. The sequencer samples in the first `WAIT_DONE` cycle.
- Latency, with `out_ready` held high:
  - B accepted in cycle N.
  - `ISSUE` in N+1.
  - `done` sampled in N+2.
  - `out_valid` in N+3.
- Throughput is one pair per 5 cycles minimum.
- Downstream backpressure: `out_ready` low holds `EMIT` indefinitely. No new enable is issued.
- Reset mid-operation: all state is cleared asynchronously and any pending pair is dropped. `add_enable` goes 0 immediately.
- `in_last` on A: the pad pair (A,0) is issued. `out_last`=1.

## Configuration
- `CONV2_DONE_TIMEOUT_EN` defined:
  - A counter runs in `WAIT_DONE`.
  - If `add_done` is not seen within `TIMEOUT_CYCLES`, set `timeout_err`=1 (sticky until reset).
  - Emit `out_data`=0 with the saved `out_last`, then continue.
- Not defined:
  - No counter.
  - `WAIT_DONE` waits for `add_done` indefinitely.
  - `timeout_err` is tied 0.

## Structure
- Shared package `conv2_pkg`:
  - FSM state enum.
  - Widths `PSUM_W`=14 and `SUM_W`=15.
- One natural sub-module: `conv2_stage3_timeout_ctr`. It is instantiated only under `CONV2_DONE_TIMEOUT_EN`.

## Test plan
- Pair issue: input 100, then 200 (`in_last`=0), with a behavioural adder model → one enable pulse with operands 100/200, then `out_data`=300 and `out_last`=0.
- Sign extension: input -8192 and -8192 → `out_data`=-16384 (15'h4000).
- Odd pad: input 5, 7, 9 with `in_last` on 9 → outputs 12 (`out_last`=0), then 9 (`out_last`=1). The second enable carries operands 9/0.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → `out_data` is stable, `in_ready`=0, and no further enable; release → handshake completes and `GET_A` resumes.
- Reset mid-`WAIT_DONE`: assert `reset` one cycle after the enable → all outputs 0 immediately, and no `out_valid` is produced for the dropped pair.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): the adder model never asserts `done` → `timeout_err`=1 after 8 cycles in `WAIT_DONE`, then `out_data`=0 is emitted.

Source files
------------

// File: rtl/conv2_pkg.sv
// Shared definitions for the conv2 stage-3 pair sequencer: operand/sum widths,
// the sequencer FSM state encoding and a small state-classification helper.
package conv2_pkg;

  localparam int PSUM_W = 14;
  localparam int SUM_W  = 15;

  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    GET_B     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    EMIT      = 3'd4
  } seq_state_t;

  // True while a pair is in flight at the adder, i.e. operands must be driven.
  function automatic logic pair_active(input seq_state_t s);
    return (s == ISSUE) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/conv2_stage3_timeout_ctr.sv
// Watchdog for the stage-3 adder handshake. Counts consecutive cycles spent
// waiting for add_done and flags expiry in the last allowed waiting cycle.
// Only instantiated when CONV2_DONE_TIMEOUT_EN is defined.
module conv2_stage3_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // The TIMEOUT_CYCLES-th waiting cycle without done is the expiry cycle.
  assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count waiting cycles; restart from zero whenever the wait is not active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (!run) begin
      count <= {CNT_W{1'b0}};
    end else if (!expired) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/conv2_stage3_pair_sequencer.sv
// Stage-3 operand issuer / result collector for conv layer 2.
// Pairs incoming 14-bit partial sums in arrival order (padding an odd final
// element with 0), fires a one-cycle enable at the stage-3 adder, captures the
// 15-bit sum on add_done and offers it downstream on a valid/ready port.
// Optional feature macro: CONV2_DONE_TIMEOUT_EN (adder done watchdog with a
// sticky timeout_err flag; without it timeout_err is tied 0).
module conv2_stage3_pair_sequencer
  import conv2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PSUM_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              add_enable,
  output logic [PSUM_W-1:0] add_input1,
  output logic [PSUM_W-1:0] add_input2,
  input  logic [SUM_W-1:0]  add_output1,
  input  logic              add_done,
  output logic              out_valid,
  output logic [SUM_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              timeout_err
);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [PSUM_W-1:0] a_r;
  logic [PSUM_W-1:0] b_r;
  logic              pair_last;
  logic [PSUM_W-1:0] a_nxt;
  logic [PSUM_W-1:0] b_nxt;
  logic              last_nxt;
  logic              in_accept;
  logic              capture;
  logic [SUM_W-1:0]  capture_data;
  logic              timeout_expired;

  assign in_accept = in_valid && in_ready;

`ifdef CONV2_DONE_TIMEOUT_EN
  logic timeout_err_r;

  conv2_stage3_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .run    (state == WAIT_DONE),
    .expired(timeout_expired)
  );

  // Sticky error: set when the wait expires without the adder answering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else if ((state == WAIT_DONE) && timeout_expired && !add_done) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_expired = 1'b0;
  assign timeout_err     = 1'b0;
`endif

  // Next-state, operand latch and result-capture decisions.
  always_comb begin
    state_nxt    = state;
    a_nxt        = a_r;
    b_nxt        = b_r;
    last_nxt     = pair_last;
    capture      = 1'b0;
    capture_data = {SUM_W{1'b0}};
    case (state)
      GET_A: begin
        if (in_accept) begin
          a_nxt = in_data;
          if (in_last) begin
            // Odd element count: pair the final value with zero.
            b_nxt     = {PSUM_W{1'b0}};
            last_nxt  = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = GET_B;
          end
        end else begin
          state_nxt = GET_A;
        end
      end
      GET_B: begin
        if (in_accept) begin
          b_nxt     = in_data;
          last_nxt  = in_last;
          state_nxt = ISSUE;
        end else begin
          state_nxt = GET_B;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (add_done) begin
          capture      = 1'b1;
          capture_data = add_output1;
          state_nxt    = EMIT;
        end else if (timeout_expired) begin
          // Watchdog fired: emit a zero sum but keep the window marker.
          capture      = 1'b1;
          capture_data = {SUM_W{1'b0}};
          state_nxt    = EMIT;
        end else begin
          state_nxt = WAIT_DONE;
        end
      end
      EMIT: begin
        if (out_valid && out_ready) begin
          state_nxt = GET_A;
        end else begin
          state_nxt = EMIT;
        end
      end
      default: begin
        state_nxt = GET_A;
      end
    endcase
  end

  // State, operands and all outputs are registered from the next-state view.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= GET_A;
      a_r        <= {PSUM_W{1'b0}};
      b_r        <= {PSUM_W{1'b0}};
      pair_last  <= 1'b0;
      in_ready   <= 1'b0;
      add_enable <= 1'b0;
      add_input1 <= {PSUM_W{1'b0}};
      add_input2 <= {PSUM_W{1'b0}};
      out_valid  <= 1'b0;
      out_data   <= {SUM_W{1'b0}};
      out_last   <= 1'b0;
    end else begin
      state      <= state_nxt;
      a_r        <= a_nxt;
      b_r        <= b_nxt;
      pair_last  <= last_nxt;
      in_ready   <= (state_nxt == GET_A) || (state_nxt == GET_B);
      add_enable <= (state_nxt == ISSUE);
      add_input1 <= pair_active(state_nxt) ? a_nxt : {PSUM_W{1'b0}};
      add_input2 <= pair_active(state_nxt) ? b_nxt : {PSUM_W{1'b0}};
      out_valid  <= (state_nxt == EMIT);
      if (capture) begin
        out_data <= capture_data;
        out_last <= pair_last;
      end else begin
        out_data <= out_data;
        out_last <= out_last;
      end
    end
  end

endmodule

// File: tb/tb_conv2_stage3_pair_sequencer.sv
// Self-checking bench for conv2_stage3_pair_sequencer: a pair-level reference
// model checked every cycle, directed scenarios with literal expectations and a
// randomized traffic phase. Timeout scenario only with CONV2_DONE_TIMEOUT_EN.
module tb_conv2_stage3_pair_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [13:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        add_enable;
  logic [13:0] add_input1;
  logic [13:0] add_input2;
  logic [14:0] add_output1;
  logic        add_done;
  logic        out_valid;
  logic [14:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        timeout_err;

  int vectors    = 0;
  int miscompares = 0;
  bit check_en   = 1'b1;
  bit hang       = 1'b0;

  // Reference model: at most one completed pair in flight, aged in cycles.
  bit          have_a = 1'b0;
  logic [13:0] held_a;
  bit          busy   = 1'b0;
  int          age    = 0;
  bit          armed  = 1'b0;
  logic [13:0] pa, pb;
  logic [14:0] psum;
  logic        plast;

  conv2_stage3_pair_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .add_enable(add_enable),
    .add_input1(add_input1), .add_input2(add_input2),
    .add_output1(add_output1), .add_done(add_done), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural stage-3 adder: done and sum one cycle after the enable.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      add_done    <= 1'b0;
      add_output1 <= 15'd0;
    end else begin
      add_done    <= add_enable && !hang;
      add_output1 <= {add_input1[13], add_input1} + {add_input2[13], add_input2};
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] sext_sum(input logic [13:0] a, input logic [13:0] b);
    return {a[13], a} + {b[13], b};
  endfunction

  // Per-cycle comparison against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready",   {15'd0, in_ready},   16'd0);
      chk("rst_add_enable", {15'd0, add_enable}, 16'd0);
      chk("rst_add_input1", {2'd0, add_input1},  16'd0);
      chk("rst_add_input2", {2'd0, add_input2},  16'd0);
      chk("rst_out_valid",  {15'd0, out_valid},  16'd0);
      chk("rst_out_data",   {1'd0, out_data},    16'd0);
      chk("rst_out_last",   {15'd0, out_last},   16'd0);
      chk("rst_timeout",    {15'd0, timeout_err}, 16'd0);
      have_a = 1'b0; busy = 1'b0; age = 0; armed = 1'b0;
    end else if (check_en) begin
      bit exp_rdy, exp_en, exp_ops, exp_vld;
      exp_rdy = armed && !busy;
      exp_en  = busy && (age == 1);
      exp_ops = busy && (age == 1 || age == 2);
      exp_vld = busy && (age >= 3);
      chk("in_ready",   {15'd0, in_ready},   {15'd0, exp_rdy});
      chk("add_enable", {15'd0, add_enable}, {15'd0, exp_en});
      chk("add_input1", {2'd0, add_input1},  {2'd0, (exp_ops ? pa : 14'd0)});
      chk("add_input2", {2'd0, add_input2},  {2'd0, (exp_ops ? pb : 14'd0)});
      chk("out_valid",  {15'd0, out_valid},  {15'd0, exp_vld});
      chk("timeout_err", {15'd0, timeout_err}, 16'd0);
      if (exp_vld) begin
        chk("out_data", {1'd0, out_data}, {1'd0, psum});
        chk("out_last", {15'd0, out_last}, {15'd0, plast});
      end
      if (busy) begin
        if (exp_vld && out_ready) busy = 1'b0;
        else age++;
      end
      if (exp_rdy && in_valid) begin
        if (!have_a) begin
          if (in_last) begin
            pa = in_data; pb = 14'd0; plast = 1'b1;
            psum = sext_sum(pa, pb); busy = 1'b1; age = 1;
          end else begin
            held_a = in_data; have_a = 1'b1;
          end
        end else begin
          pa = held_a; pb = in_data; plast = in_last;
          psum = sext_sum(pa, pb); busy = 1'b1; age = 1; have_a = 1'b0;
        end
      end
      armed = 1'b1;
    end
  end

  // Offer one partial sum; returns #1 after the edge that accepted it.
  task automatic send(input logic [13:0] d, input logic l);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_data = 14'd0; in_last = 1'b0;
    if (!ok) chk("send_accept_timeout", 16'd0, 16'd1);
  endtask

  // Wait for out_valid (out_ready assumed high) and compare against literals.
  task automatic expect_out(input string name, input logic [14:0] d, input logic l);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        chk(name, {1'd0, out_data}, {1'd0, d});
        chk({name, "_last"}, {15'd0, out_last}, {15'd0, l});
      end
    end
    if (!seen) chk({name, "_no_valid"}, 16'd0, 16'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_issue(input string name, input logic [13:0] a, input logic [13:0] b);
    chk({name, "_en"}, {15'd0, add_enable}, 16'd1);
    chk({name, "_in1"}, {2'd0, add_input1}, {2'd0, a});
    chk({name, "_in2"}, {2'd0, add_input2}, {2'd0, b});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 14'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {15'd0, in_ready}, 16'd0);
    chk("reset_out_data", {1'd0, out_data}, 16'd0);
    reset = 1'b0;

    // Basic pair 100 + 200.
    send(14'd100, 1'b0);
    send(14'd200, 1'b0);
    check_issue("pair1", 14'd100, 14'd200);
    expect_out("pair1_sum", 15'd300, 1'b0);

    // Most negative operands: -8192 + -8192 = -16384.
    send(14'h2000, 1'b0);
    send(14'h2000, 1'b0);
    check_issue("neg", 14'h2000, 14'h2000);
    expect_out("neg_sum", 15'h4000, 1'b0);

    // Odd window 5,7,9: second pair is the pad (9,0).
    send(14'd5, 1'b0);
    send(14'd7, 1'b0);
    expect_out("odd_sum1", 15'd12, 1'b0);
    send(14'd9, 1'b1);
    check_issue("pad", 14'd9, 14'd0);
    expect_out("odd_pad", 15'd9, 1'b1);

    // Backpressure: hold EMIT for 10 cycles.
    out_ready = 1'b0;
    send(14'd1, 1'b0);
    send(14'd2, 1'b0);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) chk("bp_no_valid", 16'd0, 16'd1);
    end
    for (int n = 0; n < 10; n++) begin
      chk("bp_data",   {1'd0, out_data},    16'd3);
      chk("bp_ready",  {15'd0, in_ready},   16'd0);
      chk("bp_enable", {15'd0, add_enable}, 16'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_resume_ready", {15'd0, in_ready},  16'd1);
    chk("bp_resume_valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk); #1;

    // Reset one cycle after the enable: pair is dropped.
    send(14'd10, 1'b0);
    send(14'd20, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_enable", {15'd0, add_enable}, 16'd0);
    chk("midrst_in1",    {2'd0, add_input1},  16'd0);
    chk("midrst_valid",  {15'd0, out_valid},  16'd0);
    chk("midrst_ready",  {15'd0, in_ready},   16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("midrst_dropped", {15'd0, out_valid}, 16'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = (r == 0) ? 14'h2000 : (r == 1) ? 14'h1FFF : 14'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

`ifdef CONV2_DONE_TIMEOUT_EN
    // Adder never answers: error after 8 waiting cycles, zero sum emitted.
    check_en = 1'b0;
    hang = 1'b1;
    send(14'd3, 1'b0);
    send(14'd4, 1'b0);
    @(posedge clk); #1;
    for (int n = 0; n < 8; n++) begin
      chk("to_err_early",   {15'd0, timeout_err}, 16'd0);
      chk("to_valid_early", {15'd0, out_valid},   16'd0);
      @(posedge clk); #1;
    end
    chk("to_err",   {15'd0, timeout_err}, 16'd1);
    chk("to_valid", {15'd0, out_valid},   16'd1);
    chk("to_data",  {1'd0, out_data},     16'd0);
    chk("to_last",  {15'd0, out_last},    16'd0);
    @(posedge clk); #1;
    chk("to_sticky", {15'd0, timeout_err}, 16'd1);
    chk("to_resume", {15'd0, in_ready},    16'd1);
    hang = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
